// File: rtl/circuit1_seq_ctrl_if.sv
// Request/result bundle for the multicycle Circuit1 scheduler.
// master drives operands and control, slave returns status and results.
interface circuit1_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                start;
  logic                abort;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic [DATA_W-1:0]   c;
  logic                busy;
  logic                done;
  logic                gt;
  logic                eq;
  logic [DATA_W-1:0]   z;
  logic [2*DATA_W-1:0] x;

  modport master (
    output start, abort, a, b, c,
    input  busy, done, gt, eq, z, x
  );

  modport slave (
    input  start, abort, a, b, c,
    output busy, done, gt, eq, z, x
  );
endinterface

// File: rtl/circuit1_seq_ctrl.sv
// Circuit1 (z = max(a+b, a+c), x = a*c - (a+b)) computed over several
// cycles on a single shared 2*DATA_W-bit adder/subtractor.
module circuit1_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  circuit1_seq_ctrl_if.slave bus
);

  localparam int W2 = 2 * DATA_W;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_D,
    S_ADD_E,
    S_CMP,
    S_MUL,
    S_SUB,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_e;
  logic [DATA_W-1:0] r_zsel;
  logic              r_g;
  logic              r_eq;
  logic [W2-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;

  logic [DATA_W-1:0] r_z;
  logic [W2-1:0]     r_x;
  logic              r_gt;
  logic              r_eqo;

  logic [W2-1:0]     w_opa;
  logic [W2-1:0]     w_opb;
  logic              w_sub;
  logic [W2-1:0]     w_sum;
  logic              w_busy;
  logic              w_done;
  logic              w_zero;
  logic              w_gt;
  logic              w_kill;

  logic [W2-1:0]     w_a_ext;
  logic [W2-1:0]     w_b_ext;
  logic [W2-1:0]     w_c_ext;
  logic [W2-1:0]     w_d_ext;
  logic [W2-1:0]     w_e_ext;

  assign w_a_ext = {{DATA_W{1'b0}}, r_a};
  assign w_b_ext = {{DATA_W{1'b0}}, r_b};
  assign w_c_ext = {{DATA_W{1'b0}}, r_c};
  assign w_d_ext = {{DATA_W{1'b0}}, r_d};
  assign w_e_ext = {{DATA_W{1'b0}}, r_e};

  // The one shared adder; subtraction is add of the inverted operand plus one.
  assign w_sum = w_opa
               + (w_opb ^ {W2{w_sub}})
               + {{(W2-1){1'b0}}, w_sub};

  // d-e on zero-extended operands: top bit set means d<e.
  assign w_zero = (w_sum == '0);
  assign w_gt   = ~w_sum[W2-1] & ~w_zero;

  assign w_kill = bus.abort
                & (r_state != S_IDLE)
                & (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) w_next = S_ADD_D;
      end
      S_ADD_D: w_next = S_ADD_E;
      S_ADD_E: w_next = S_CMP;
      S_CMP:   w_next = S_MUL;
      S_MUL: begin
        if (r_cnt == CW'(DATA_W - 1)) w_next = S_SUB;
      end
      S_SUB:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_kill) w_next = S_IDLE;
  end

  always_comb begin
    w_opa  = '0;
    w_opb  = '0;
    w_sub  = 1'b0;
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
    unique case (r_state)
      S_ADD_D: begin
        w_opa = w_a_ext;
        w_opb = w_b_ext;
      end
      S_ADD_E: begin
        w_opa = w_a_ext;
        w_opb = w_c_ext;
      end
      S_CMP: begin
        w_opa = w_d_ext;
        w_opb = w_e_ext;
        w_sub = 1'b1;
      end
      S_MUL: begin
        w_opa = r_acc;
        w_opb = w_a_ext << r_cnt;
      end
      S_SUB: begin
        w_opa = r_acc;
        w_opb = w_d_ext;
        w_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_e    <= '0;
      r_zsel <= '0;
      r_g    <= 1'b0;
      r_eq   <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_z    <= '0;
      r_x    <= '0;
      r_gt   <= 1'b0;
      r_eqo  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_a <= bus.a;
            r_b <= bus.b;
            r_c <= bus.c;
          end
        end
        S_ADD_D: r_d <= w_sum[DATA_W-1:0];
        S_ADD_E: r_e <= w_sum[DATA_W-1:0];
        S_CMP: begin
          r_g    <= w_gt;
          r_eq   <= w_zero;
          r_zsel <= w_gt ? r_d : r_e;
          r_acc  <= '0;
          r_cnt  <= '0;
        end
        S_MUL: begin
          if (r_c[r_cnt]) r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
        end
        S_SUB: begin
          r_acc <= w_sum;
          // Results only become visible on the edge entering DONE.
          if (!bus.abort) begin
            r_x   <= w_sum;
            r_z   <= r_zsel;
            r_gt  <= r_g;
            r_eqo <= r_eq;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eqo;
  assign bus.z    = r_z;
  assign bus.x    = r_x;

endmodule
